// File: rtl/sram_sh_tag_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_sh_tag_pkg
// Shared types and helpers for the shared-cache tag store controller.
//   sh_tag_state_e : controller FSM states (INIT = invalidate sweep, IDLE)
//   lane_width()   : stored bits per way; one extra parity bit when
//                    SH_TAG_PARITY_EN is defined
// Optional feature macro: SH_TAG_PARITY_EN
// ---------------------------------------------------------------------------
package sram_sh_tag_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } sh_tag_state_e;

  function automatic int lane_width(input int tag_width);
`ifdef SH_TAG_PARITY_EN
    return tag_width + 1;
`else
    return tag_width;
`endif
  endfunction

endpackage

// File: rtl/sram_sh_tag_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_sh_tag_ctrl_if
// Request/response bundle between the shared-cache lookup pipeline (master)
// and the tag store controller (slave).
//   FLUSH_REQ  : pulse, invalidate all sets
//   BUSY       : invalidate sweep running
//   REQ_*      : valid/ready request (WE, per-way WAY_EN, set ADDR, WDATA)
//   RSP_*      : one-cycle read response with held data and per-way parity error
// ---------------------------------------------------------------------------
interface sram_sh_tag_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int TAG_WIDTH  = 10,
  parameter int SH_NB_WAYS = 4
);

  logic                             FLUSH_REQ;
  logic                             BUSY;
  logic                             REQ_VALID;
  logic                             REQ_READY;
  logic                             REQ_WE;
  logic [SH_NB_WAYS-1:0]            REQ_WAY_EN;
  logic [ADDR_WIDTH-1:0]            REQ_ADDR;
  logic [SH_NB_WAYS*TAG_WIDTH-1:0]  REQ_WDATA;
  logic                             RSP_VALID;
  logic [SH_NB_WAYS*TAG_WIDTH-1:0]  RSP_RDATA;
  logic [SH_NB_WAYS-1:0]            RSP_PERR;

  modport master (
    output FLUSH_REQ, REQ_VALID, REQ_WE, REQ_WAY_EN, REQ_ADDR, REQ_WDATA,
    input  BUSY, REQ_READY, RSP_VALID, RSP_RDATA, RSP_PERR
  );

  modport slave (
    input  FLUSH_REQ, REQ_VALID, REQ_WE, REQ_WAY_EN, REQ_ADDR, REQ_WDATA,
    output BUSY, REQ_READY, RSP_VALID, RSP_RDATA, RSP_PERR
  );

endinterface

// File: rtl/sram_sh_tag_ctrl_mem.sv
// ---------------------------------------------------------------------------
// GENERIC_MEM
// Single-port synchronous SRAM model, NB_LANES lanes of DATA_WIDTH bits.
//   CLK   : clock
//   CEN   : chip enable, active-low
//   RDWEN : 1 = read, 0 = write
//   BW    : per-bit write enable (1 = write that bit)
//   A     : word address
//   D     : write data
//   Q     : registered read data (updated only on a read access)
// ---------------------------------------------------------------------------
module GENERIC_MEM #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 10,
  parameter int NB_LANES   = 4
) (
  input  logic                           CLK,
  input  logic                           CEN,
  input  logic                           RDWEN,
  input  logic [NB_LANES*DATA_WIDTH-1:0] BW,
  input  logic [ADDR_WIDTH-1:0]          A,
  input  logic [NB_LANES*DATA_WIDTH-1:0] D,
  output logic [NB_LANES*DATA_WIDTH-1:0] Q
);

  localparam int WIDTH = NB_LANES * DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_reg [0:DEPTH-1];
  logic [WIDTH-1:0] q_reg;

  // Bit-masked write keeps unselected lanes intact; Q only changes on reads.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!RDWEN) begin
        mem_reg[A] <= (mem_reg[A] & ~BW) | (D & BW);
      end else begin
        q_reg <= mem_reg[A];
      end
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/sram_sh_tag_ctrl.sv
// ---------------------------------------------------------------------------
// sram_sh_tag_ctrl
// Shared-cache tag store controller around one GENERIC_MEM cut holding
// SH_NB_WAYS tags per set. Invalidate sweep after reset and on FLUSH_REQ,
// valid/ready request port with per-way write enables, registered read
// response with a hold register.
//   CLK  : clock
//   RST  : synchronous reset, active-high
//   bus  : sram_sh_tag_ctrl_if.slave (FLUSH_REQ/BUSY, REQ_*, RSP_*)
// Optional feature macro: SH_TAG_PARITY_EN -- one even-parity bit per way is
// stored and checked on read (RSP_PERR); otherwise RSP_PERR is tied to 0.
// ---------------------------------------------------------------------------
module sram_sh_tag_ctrl
  import sram_sh_tag_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int TAG_WIDTH  = 10,
  parameter int SH_NB_WAYS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  sram_sh_tag_ctrl_if.slave bus
);

  localparam int LW = lane_width(TAG_WIDTH);
  localparam int MW = SH_NB_WAYS * LW;
  localparam int DW = SH_NB_WAYS * TAG_WIDTH;

  sh_tag_state_e         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;

  logic                  req_accept;
  logic                  mem_cen;
  logic                  mem_rdwen;
  logic [MW-1:0]         mem_bw;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [MW-1:0]         mem_d;
  logic [MW-1:0]         mem_q;

  logic [MW-1:0]         wdata_lanes;
  logic [MW-1:0]         bw_lanes;
  logic [DW-1:0]         rdata_q;

  logic                  rsp_valid_reg;
  logic [DW-1:0]         rdata_hold_reg;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      INIT: begin
        // FLUSH_REQ is ignored here: the running sweep is never restarted.
        ptr_next = ptr_reg + ADDR_WIDTH'(1);
        if (ptr_reg == {ADDR_WIDTH{1'b1}}) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (bus.FLUSH_REQ) begin
          state_next = INIT;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = INIT;
        ptr_next   = '0;
      end
    endcase
  end

  assign bus.BUSY      = (state_reg == INIT);
  assign bus.REQ_READY = (state_reg == IDLE);

  // A request coinciding with FLUSH_REQ is still served; the sweep follows.
  assign req_accept = bus.REQ_VALID && bus.REQ_READY && !RST;

  // ---------------- per-way lane packing ----------------
  for (genvar gi = 0; gi < SH_NB_WAYS; gi++) begin : g_lane
`ifdef SH_TAG_PARITY_EN
    // Even parity: stored bit makes the lane's XOR zero; all-zero lanes are clean.
    assign wdata_lanes[gi*LW +: LW] =
      {^bus.REQ_WDATA[gi*TAG_WIDTH +: TAG_WIDTH], bus.REQ_WDATA[gi*TAG_WIDTH +: TAG_WIDTH]};
`else
    assign wdata_lanes[gi*LW +: LW] = bus.REQ_WDATA[gi*TAG_WIDTH +: TAG_WIDTH];
`endif
    assign bw_lanes[gi*LW +: LW]          = {LW{bus.REQ_WAY_EN[gi]}};
    assign rdata_q[gi*TAG_WIDTH +: TAG_WIDTH] = mem_q[gi*LW +: TAG_WIDTH];
  end

  // ---------------- memory control ----------------
  always_comb begin
    mem_cen   = 1'b1;
    mem_rdwen = 1'b1;
    mem_bw    = '0;
    mem_a     = bus.REQ_ADDR;
    mem_d     = wdata_lanes;
    if (!RST && state_reg == INIT) begin
      mem_cen   = 1'b0;
      mem_rdwen = 1'b0;
      mem_bw    = '1;
      mem_a     = ptr_reg;
      mem_d     = '0;
    end else if (req_accept) begin
      mem_cen   = 1'b0;
      mem_rdwen = !bus.REQ_WE;
      mem_bw    = bus.REQ_WE ? bw_lanes : '0;
    end
  end

  GENERIC_MEM #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (LW),
    .NB_LANES   (SH_NB_WAYS)
  ) u_mem (
    .CLK   (CLK),
    .CEN   (mem_cen),
    .RDWEN (mem_rdwen),
    .BW    (mem_bw),
    .A     (mem_a),
    .D     (mem_d),
    .Q     (mem_q)
  );

  // ---------------- response ----------------
  // Q is only shown in the response cycle; afterwards the hold copy is shown,
  // so later accesses never leak through RSP_RDATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid_reg  <= 1'b0;
      rdata_hold_reg <= '0;
    end else begin
      rsp_valid_reg <= req_accept && !bus.REQ_WE;
      if (rsp_valid_reg) begin
        rdata_hold_reg <= rdata_q;
      end
    end
  end

  assign bus.RSP_VALID = rsp_valid_reg;
  assign bus.RSP_RDATA = rsp_valid_reg ? rdata_q : rdata_hold_reg;

`ifdef SH_TAG_PARITY_EN
  logic [SH_NB_WAYS-1:0] perr_q;
  logic [SH_NB_WAYS-1:0] perr_hold_reg;

  for (genvar gi = 0; gi < SH_NB_WAYS; gi++) begin : g_perr
    assign perr_q[gi] = ^mem_q[gi*LW +: LW];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perr_hold_reg <= '0;
    end else if (rsp_valid_reg) begin
      perr_hold_reg <= perr_q;
    end
  end

  assign bus.RSP_PERR = rsp_valid_reg ? perr_q : perr_hold_reg;
`else
  assign bus.RSP_PERR = '0;
`endif

endmodule

// File: tb/tb_sram_sh_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_sh_tag_ctrl
// Directed self-checking bench for sram_sh_tag_ctrl (ADDR_WIDTH=4,
// TAG_WIDTH=10, SH_NB_WAYS=4). Inputs change and outputs are sampled on the
// falling clock edge. The parity scenario is compiled when SH_TAG_PARITY_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_sram_sh_tag_ctrl;

  localparam int AW = 4;
  localparam int TW = 10;
  localparam int NW = 4;
  localparam int DW = NW * TW;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  sram_sh_tag_ctrl_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .SH_NB_WAYS(NW)) bus ();

  sram_sh_tag_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .SH_NB_WAYS(NW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] set5_data;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.FLUSH_REQ  = 1'b0;
    bus.REQ_VALID  = 1'b0;
    bus.REQ_WE     = 1'b0;
    bus.REQ_WAY_EN = '0;
    bus.REQ_ADDR   = '0;
    bus.REQ_WDATA  = '0;
  endtask

  // Called at a falling edge; returns the number of samples with BUSY=1 (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (bus.BUSY === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [NW-1:0] en, input logic [DW-1:0] d);
    bus.REQ_VALID  = 1'b1;
    bus.REQ_WE     = 1'b1;
    bus.REQ_ADDR   = a;
    bus.REQ_WAY_EN = en;
    bus.REQ_WDATA  = d;
    @(negedge CLK);
    bus.REQ_VALID  = 1'b0;
    bus.REQ_WE     = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic v,
                         output logic [DW-1:0] d, output logic [NW-1:0] p);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = a;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    v = bus.RSP_VALID;
    d = bus.RSP_RDATA;
    p = bus.RSP_PERR;
  endtask

  task automatic test_reset();
    int n;
    logic v;
    logic [DW-1:0] d;
    logic [NW-1:0] p;
    idle_inputs();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", bus.BUSY); end
    checks++; if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.REQ_READY); end
    checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.RSP_VALID); end
    checks++; if (bus.RSP_RDATA !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.RSP_RDATA); end
    checks++; if (bus.RSP_PERR !== '0) begin errors++; $display("FAIL reset_perr got=%b exp=0", bus.RSP_PERR); end
    RST = 1'b0;
    count_busy(n);
    checks++; if (n != 16) begin errors++; $display("FAIL reset_sweep_len got=%0d exp=16", n); end
    checks++; if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", bus.REQ_READY); end
    $display("reset: sweep busy cycles=%0d", n);
    for (int s = 0; s < 16; s++) begin
      do_read(AW'(s), v, d, p);
      checks++; if (v !== 1'b1 || d !== '0 || p !== '0) begin
        errors++; $display("FAIL reset_read set=%0d got v=%b d=%h p=%b exp v=1 d=0 p=0", s, v, d, p);
      end
    end
    $display("reset: read back 16 sets");
  endtask

  task automatic test_write_way_en();
    logic v;
    logic [DW-1:0] d, nd, exp_d;
    logic [NW-1:0] p;
    set5_data = 40'hA5A5A5A5A5;
    do_write(4'd5, 4'b1111, set5_data);
    checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL write_no_rsp got=%b exp=0", bus.RSP_VALID); end
    do_read(4'd5, v, d, p);
    checks++; if (v !== 1'b1 || d !== set5_data) begin
      errors++; $display("FAIL write_full_read got v=%b d=%h exp v=1 d=%h", v, d, set5_data);
    end
    $display("write set5 full: read d=%h", d);
    nd = 40'h123456789A;
    do_write(4'd5, 4'b0010, nd);
    exp_d = {set5_data[39:20], nd[19:10], set5_data[9:0]};
    do_read(4'd5, v, d, p);
    checks++; if (v !== 1'b1 || d !== exp_d) begin
      errors++; $display("FAIL write_way1_read got v=%b d=%h exp v=1 d=%h", v, d, exp_d);
    end
    set5_data = exp_d;
    $display("write set5 way1: read d=%h", d);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [1:3];
    exp_d[1] = 40'h0040100401;
    exp_d[2] = 40'h3FF003FF00;
    exp_d[3] = 40'h1234512345;
    for (int s = 1; s <= 3; s++) do_write(AW'(s), 4'b1111, exp_d[s]);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = 4'd1;
    @(negedge CLK);
    for (int s = 1; s <= 3; s++) begin
      checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== exp_d[s]) begin
        errors++; $display("FAIL b2b_rsp set=%0d got v=%b d=%h exp v=1 d=%h", s, bus.RSP_VALID, bus.RSP_RDATA, exp_d[s]);
      end
      $display("b2b read set=%0d d=%h", s, bus.RSP_RDATA);
      if (s < 3) bus.REQ_ADDR = AW'(s + 1);
      else       bus.REQ_VALID = 1'b0;
      @(negedge CLK);
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (bus.RSP_VALID !== 1'b0 || bus.RSP_RDATA !== exp_d[3]) begin
        errors++; $display("FAIL b2b_hold got v=%b d=%h exp v=0 d=%h", bus.RSP_VALID, bus.RSP_RDATA, exp_d[3]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_flush_with_read();
    int n;
    logic v;
    logic [DW-1:0] d;
    logic [NW-1:0] p;
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = 1'b0;
    bus.REQ_ADDR  = 4'd5;
    bus.FLUSH_REQ = 1'b1;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    bus.FLUSH_REQ = 1'b0;
    checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== set5_data) begin
      errors++; $display("FAIL flush_read got v=%b d=%h exp v=1 d=%h", bus.RSP_VALID, bus.RSP_RDATA, set5_data);
    end
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL flush_busy got=%b exp=1", bus.BUSY); end
    n = 0;
    while (bus.BUSY === 1'b1 && n < 100) begin
      n++;
      bus.FLUSH_REQ = (n == 8);
      @(negedge CLK);
    end
    bus.FLUSH_REQ = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL flush_sweep_len got=%0d exp=16", n); end
    $display("flush: sweep busy cycles=%0d", n);
    do_read(4'd5, v, d, p);
    checks++; if (v !== 1'b1 || d !== '0) begin
      errors++; $display("FAIL flush_set5_cleared got v=%b d=%h exp v=1 d=0", v, d);
    end
  endtask

  task automatic test_rst_mid_sweep();
    int n;
    logic v;
    logic [DW-1:0] d;
    logic [NW-1:0] p;
    do_write(4'd12, 4'b1111, 40'hFFFFFFFFFF);
    bus.FLUSH_REQ = 1'b1;
    @(negedge CLK);
    bus.FLUSH_REQ = 1'b0;
    repeat (7) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    count_busy(n);
    checks++; if (n != 16) begin errors++; $display("FAIL rst_mid_sweep_len got=%0d exp=16", n); end
    $display("rst mid-sweep: busy cycles=%0d", n);
    for (int s = 0; s < 16; s++) begin
      do_read(AW'(s), v, d, p);
      checks++; if (v !== 1'b1 || d !== '0) begin
        errors++; $display("FAIL rst_mid_read set=%0d got v=%b d=%h exp v=1 d=0", s, v, d);
      end
    end
  endtask

`ifdef SH_TAG_PARITY_EN
  task automatic test_parity();
    logic v;
    logic [DW-1:0] d;
    logic [NW-1:0] p;
    logic [NW*(TW+1)-1:0] flip;
    do_write(4'd3, 4'b1111, 40'h0AB5566778);
    do_write(4'd4, 4'b1111, 40'h0AB5566778);
    flip = '0;
    flip[2*(TW+1)] = 1'b1;
    dut.u_mem.mem_reg[3] = dut.u_mem.mem_reg[3] ^ flip;
    do_read(4'd3, v, d, p);
    checks++; if (v !== 1'b1 || p !== 4'b0100) begin
      errors++; $display("FAIL parity_set3 got v=%b p=%b exp v=1 p=0100", v, p);
    end
    do_read(4'd4, v, d, p);
    checks++; if (v !== 1'b1 || p !== 4'b0000) begin
      errors++; $display("FAIL parity_set4 got v=%b p=%b exp v=1 p=0000", v, p);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_way_en();
    test_back_to_back();
    test_flush_with_read();
    test_rst_mid_sweep();
`ifdef SH_TAG_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
